// File: rtl/nonce_exchange.sv
// Nonce exchange: collects an 8-word client nonce, pairs it with LFSR words,
// kicks the KDF and hands the resulting session key to the consumer.
module nonce_exchange #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] LFSR_SEED      = 32'hACE12468
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         abort,
    output logic         kdf_start,
    input  logic         kdf_complete,
    input  logic [255:0] session_key_in,
    output logic [255:0] nonce_client,
    output logic [255:0] nonce_fpga,
    output logic [255:0] key_out,
    output logic         key_valid,
    input  logic         key_ack,
    output logic         busy,
    output logic         err,
    input  logic         err_clear
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        START,
        WAIT,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] POLY     = 32'h80200003;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic [31:0] lfsr, lfsr_nx;
    logic [2:0]  word_cnt;
    logic [7:0]  tmo_cnt;
    logic        xfer;
    logic        wipe;
    logic        latch_key;
    logic        tmo_inc;

    assign lfsr_nx   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
    assign s_ready   = (state == IDLE) || (state == COLLECT);
    assign xfer      = s_valid && s_ready && !abort;
    assign kdf_start = (state == START);
    assign key_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign err       = (state == ERR);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        wipe      = 1'b0;
        latch_key = 1'b0;
        tmo_inc   = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            wipe     = 1'b1;
        end else begin
            unique case (state)
                IDLE:    if (xfer) state_nx = COLLECT;
                COLLECT: if (xfer && word_cnt == 3'd7) state_nx = START;
                START:   state_nx = WAIT;
                WAIT: begin
                    // tmo_cnt == 0 marks the first WAIT cycle: a stale
                    // complete level from a previous run is masked there
                    if (tmo_cnt != 8'd0 && kdf_complete) begin
                        latch_key = 1'b1;
                        state_nx  = DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_nx = ERR;
                    end else begin
                        tmo_inc = 1'b1;
                    end
                end
                DONE: begin
                    if (key_ack) begin
                        wipe     = 1'b1;
                        state_nx = IDLE;
                    end
                end
                ERR: begin
                    if (err_clear) begin
                        wipe     = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr         <= LFSR_SEED;
            word_cnt     <= 3'd0;
            tmo_cnt      <= 8'd0;
            nonce_client <= '0;
            nonce_fpga   <= '0;
            key_out      <= '0;
        end else begin
            lfsr <= lfsr_nx;
            if (wipe) begin
                word_cnt     <= 3'd0;
                tmo_cnt      <= 8'd0;
                nonce_client <= '0;
                nonce_fpga   <= '0;
                key_out      <= '0;
            end else begin
                if (xfer) begin
                    if (state == IDLE) begin
                        nonce_client <= {224'b0, s_data};
                        nonce_fpga   <= {224'b0, lfsr};
                        word_cnt     <= 3'd1;
                    end else begin
                        nonce_client[{word_cnt, 5'b0} +: 32] <= s_data;
                        nonce_fpga[{word_cnt, 5'b0} +: 32]   <= lfsr;
                        word_cnt <= word_cnt + 3'd1;
                    end
                end
                if (state == START) tmo_cnt <= 8'd0;
                else if (tmo_inc)   tmo_cnt <= tmo_cnt + 8'd1;
                if (latch_key) key_out <= session_key_in;
            end
        end
    end

endmodule

// File: tb/tb_nonce_exchange.sv
// Directed bench for nonce_exchange: nominal run, LFSR, timeout,
// stale complete, abort/reset and backpressure scenarios.
module tb_nonce_exchange;

    localparam logic [31:0] SEED = 32'hACE12468;
    localparam logic [255:0] KEY_A5 = {32{8'hA5}};
    localparam logic [255:0] KEY_B = {8{32'h12345678}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         abort = 1'b0;
    logic         kdf_start;
    logic         kdf_complete = 1'b0;
    logic [255:0] session_key_in = '0;
    logic [255:0] nonce_client;
    logic [255:0] nonce_fpga;
    logic [255:0] key_out;
    logic         key_valid;
    logic         key_ack = 1'b0;
    logic         busy;
    logic         err;
    logic         err_clear = 1'b0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [31:0]  m;
    logic [31:0]  words [8];
    logic [31:0]  exp_f [8];
    logic [255:0] exp_client;
    logic [255:0] exp_fpga;

    nonce_exchange #(.TIMEOUT_CYCLES(64), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .abort(abort), .kdf_start(kdf_start),
        .kdf_complete(kdf_complete), .session_key_in(session_key_in),
        .nonce_client(nonce_client), .nonce_fpga(nonce_fpga),
        .key_out(key_out), .key_valid(key_valid), .key_ack(key_ack),
        .busy(busy), .err(err), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] s;
        s = {1'b0, v[31:1]};
        return v[0] ? (s ^ 32'h80200003) : s;
    endfunction

    always @(posedge clk) begin
        if (reset) m <= SEED;
        else       m <= lfsr_next(m);
        if (!reset && kdf_start) start_cnt <= start_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        s_valid = 1'b0;
        abort = 1'b0;
        kdf_complete = 1'b0;
        key_ack = 1'b0;
        err_clear = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic set_words(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < 8; k++) begin
            words[k] = base + step * k;
            exp_client[32*k +: 32] = words[k];
        end
    endtask

    task automatic send(input int gap, input int n);
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data = words[k];
            exp_f[k] = m;
            tick;
            s_valid = 1'b0;
            if (k < 7) repeat (gap) tick;
        end
        for (int k = 0; k < 8; k++) exp_fpga[32*k +: 32] = exp_f[k];
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        checks++; if (kdf_start !== 1'b0) begin errors++; $display("FAIL reset_kdf_start: got %b want 0", kdf_start); end
        checks++; if (key_out !== '0) begin errors++; $display("FAIL reset_key_out: got %h want 0", key_out); end
        checks++; if (nonce_client !== '0 || nonce_fpga !== '0) begin errors++; $display("FAIL reset_nonces: got %h / %h want 0", nonce_client, nonce_fpga); end
    endtask

    task automatic test_nominal;
        int b;
        set_words(32'd1, 32'd1);
        session_key_in = KEY_A5;
        do_reset;
        b = start_cnt;
        send(0, 8);
        checks++; if (kdf_start !== 1'b1) begin errors++; $display("FAIL nom_start: got %b want 1", kdf_start); end
        checks++; if (nonce_client[31:0] !== 32'd1) begin errors++; $display("FAIL nom_client_lo: got %h want 1", nonce_client[31:0]); end
        checks++; if (nonce_client[255:224] !== 32'd8) begin errors++; $display("FAIL nom_client_hi: got %h want 8", nonce_client[255:224]); end
        checks++; if (nonce_client !== exp_client) begin errors++; $display("FAIL nom_client: got %h want %h", nonce_client, exp_client); end
        checks++; if (nonce_fpga[31:0] !== 32'hACE12468) begin errors++; $display("FAIL lfsr_w0: got %h want ace12468", nonce_fpga[31:0]); end
        checks++; if (nonce_fpga[63:32] !== 32'h56709234) begin errors++; $display("FAIL lfsr_w1: got %h want 56709234", nonce_fpga[63:32]); end
        checks++; if (nonce_fpga[95:64] !== 32'h2B38491A) begin errors++; $display("FAIL lfsr_w2: got %h want 2b38491a", nonce_fpga[95:64]); end
        checks++; if (nonce_fpga[127:96] !== 32'h159C248D) begin errors++; $display("FAIL lfsr_w3: got %h want 159c248d", nonce_fpga[127:96]); end
        checks++; if (nonce_fpga[159:128] !== 32'h8AEE1245) begin errors++; $display("FAIL lfsr_w4: got %h want 8aee1245", nonce_fpga[159:128]); end
        checks++; if (nonce_fpga !== exp_fpga) begin errors++; $display("FAIL lfsr_all: got %h want %h", nonce_fpga, exp_fpga); end
        repeat (11) tick;
        kdf_complete = 1'b1;
        tick;
        kdf_complete = 1'b0;
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL nom_key_valid: got %b want 1", key_valid); end
        checks++; if (key_out !== KEY_A5) begin errors++; $display("FAIL nom_key_out: got %h want %h", key_out, KEY_A5); end
        checks++; if (nonce_client !== exp_client || nonce_fpga !== exp_fpga) begin errors++; $display("FAIL nom_nonce_stable: got %h / %h", nonce_client, nonce_fpga); end
        checks++; if (start_cnt - b !== 1) begin errors++; $display("FAIL nom_single_start: got %0d want 1", start_cnt - b); end
        key_ack = 1'b1;
        tick;
        key_ack = 1'b0;
        checks++; if (key_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nom_ack_state: got kv=%b busy=%b want 0 0", key_valid, busy); end
        checks++; if (key_out !== '0 || nonce_client !== '0 || nonce_fpga !== '0) begin errors++; $display("FAIL nom_ack_clear: got %h / %h / %h want 0", key_out, nonce_client, nonce_fpga); end
    endtask

    task automatic test_timeout;
        int n;
        set_words(32'hDEAD0000, 32'h11);
        do_reset;
        send(0, 8);
        tick;
        n = 0;
        while (err !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        checks++; if (n !== 64) begin errors++; $display("FAIL tmo_cycles: got %0d want 64", n); end
        checks++; if (busy !== 1'b1 || key_valid !== 1'b0) begin errors++; $display("FAIL tmo_err_state: got busy=%b kv=%b want 1 0", busy, key_valid); end
        repeat (3) tick;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_hold: got %b want 1", err); end
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0;
        checks++; if (err !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL tmo_clear_state: got err=%b busy=%b rdy=%b", err, busy, s_ready); end
        checks++; if (nonce_client !== '0 || nonce_fpga !== '0 || key_out !== '0) begin errors++; $display("FAIL tmo_clear_data: got %h / %h want 0", nonce_client, nonce_fpga); end
    endtask

    task automatic test_stale;
        set_words(32'h00C0FFEE, 32'h3);
        session_key_in = KEY_B;
        do_reset;
        kdf_complete = 1'b1;
        send(0, 8);
        checks++; if (kdf_start !== 1'b1) begin errors++; $display("FAIL stale_start: got %b want 1", kdf_start); end
        tick;
        tick;
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL stale_first_wait: got %b want 0", key_valid); end
        tick;
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL stale_second_wait: got %b want 1", key_valid); end
        checks++; if (key_out !== KEY_B) begin errors++; $display("FAIL stale_key: got %h want %h", key_out, KEY_B); end
        kdf_complete = 1'b0;
        key_ack = 1'b1;
        tick;
        key_ack = 1'b0;
    endtask

    task automatic test_abort;
        int b;
        set_words(32'h40000000, 32'h1);
        do_reset;
        b = start_cnt;
        send(0, 4);
        s_valid = 1'b1;
        s_data = words[4];
        abort = 1'b1;
        tick;
        abort = 1'b0;
        s_valid = 1'b0;
        checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL abort_state: got busy=%b rdy=%b want 0 1", busy, s_ready); end
        checks++; if (nonce_client !== '0 || nonce_fpga !== '0) begin errors++; $display("FAIL abort_nonces: got %h / %h want 0", nonce_client, nonce_fpga); end
        repeat (15) tick;
        checks++; if (start_cnt !== b) begin errors++; $display("FAIL abort_no_start: got %0d want %0d", start_cnt, b); end
        session_key_in = KEY_A5;
        send(0, 8);
        tick;
        tick;
        kdf_complete = 1'b1;
        tick;
        kdf_complete = 1'b0;
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL rst_done_pre: got %b want 1", key_valid); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (key_valid !== 1'b0 || key_out !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rst_done: got kv=%b key=%h busy=%b", key_valid, key_out, busy); end
        send(0, 8);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        b = start_cnt;
        repeat (10) tick;
        checks++; if (start_cnt !== b || busy !== 1'b0) begin errors++; $display("FAIL rst_wait: got starts=%0d busy=%b want %0d 0", start_cnt, busy, b); end
    endtask

    task automatic test_backpressure;
        int bad;
        set_words(32'd1, 32'd1);
        session_key_in = KEY_A5;
        do_reset;
        send(3, 8);
        checks++; if (nonce_client !== exp_client) begin errors++; $display("FAIL bp_client: got %h want %h", nonce_client, exp_client); end
        checks++; if (nonce_fpga[31:0] !== SEED) begin errors++; $display("FAIL bp_fpga_w0: got %h want %h", nonce_fpga[31:0], SEED); end
        checks++; if (nonce_fpga !== exp_fpga) begin errors++; $display("FAIL bp_fpga: got %h want %h", nonce_fpga, exp_fpga); end
        tick;
        tick;
        kdf_complete = 1'b1;
        tick;
        kdf_complete = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (key_valid !== 1'b1 || key_out !== KEY_A5) bad++;
            tick;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_key_hold: got %0d bad cycles want 0", bad); end
        key_ack = 1'b1;
        tick;
        key_ack = 1'b0;
        checks++; if (key_out !== '0 || key_valid !== 1'b0) begin errors++; $display("FAIL bp_ack: got kv=%b key=%h want 0", key_valid, key_out); end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_timeout;
        test_stale;
        test_abort;
        test_backpressure;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
